// File: rtl/accum_sequencer.sv
// accum_sequencer: accumulator controller driving an external adder/subtractor.
// Ports: clk/rst_n, in_* command handshake, as_* adder link, acc + C/V/Z flags, out_valid/busy.
module accum_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op_code,
  input  logic [WIDTH-1:0] operand,
  input  logic [CNT_W-1:0] repeat_n,
  output logic [WIDTH-1:0] as_num1,
  output logic [WIDTH-1:0] as_num2,
  output logic             as_m,
  input  logic [WIDTH-1:0] as_sum,
  input  logic             as_c_out,
  input  logic             as_overflow,
  output logic [WIDTH-1:0] acc,
  output logic             flag_c,
  output logic             flag_v,
  output logic             flag_z,
  output logic             out_valid,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_ADD   = 2'b01;
  localparam logic [1:0] OP_SUB   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  state_t           r_state;
  state_t           w_next;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_operand;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_acc;
  logic             r_c;
  logic             r_v;

  logic w_accept;
  logic w_arith;
  logic w_rep0;

  assign w_accept = in_valid && (r_state == S_IDLE);
  assign w_arith  = (op_code == OP_ADD) || (op_code == OP_SUB);
  assign w_rep0   = (repeat_n == '0);

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign out_valid = (r_state == S_DONE);

  assign as_num1 = r_acc;
  assign as_num2 = r_operand;
  assign as_m    = (r_op == OP_SUB);

  assign acc    = r_acc;
  assign flag_c = r_c;
  assign flag_v = r_v;
  assign flag_z = (r_acc == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_arith && !w_rep0) w_next = S_EXEC;
          else                    w_next = S_DONE;
        end
      end
      S_EXEC: begin
        // last iteration lands on this edge
        if (r_cnt == CNT_W'(1)) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op      <= '0;
      r_operand <= '0;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_c       <= 1'b0;
      r_v       <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op      <= op_code;
            r_operand <= operand;
            r_cnt     <= repeat_n;
            r_v       <= 1'b0;
            unique case (op_code)
              OP_LOAD: begin
                r_acc <= operand;
                r_c   <= 1'b0;
              end
              OP_CLEAR: begin
                r_acc <= '0;
                r_c   <= 1'b0;
              end
              OP_ADD, OP_SUB: begin
                if (w_rep0) r_c <= 1'b0;
              end
              default: ;
            endcase
          end
        end
        S_EXEC: begin
          r_acc <= as_sum;
          r_c   <= as_c_out;
          r_v   <= r_v | as_overflow;
          r_cnt <= r_cnt - CNT_W'(1);
        end
        S_DONE:  ;
        default: ;
      endcase
    end
  end

endmodule
